sat_down_cntr: RTL and testbench

SAT_DOWN_CNTR -- requirements
Module: sat_down_cntr

---
 rtl/sat_down_cntr_pkg.sv | 14 +
 rtl/sat_down_cntr_if.sv | 31 +++
 rtl/sat_down_cntr_tick_gen.sv | 33 +++
 rtl/sat_down_cntr.sv | 94 +++++++++
 tb/tb_sat_down_cntr.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/sat_down_cntr_pkg.sv
// Shared definitions for the saturating down-counter: width/floor/prescale
// defaults and the FSM state encoding.
package sat_down_cntr_pkg;

    localparam int CNTR_WIDTH_DEF = 4;
    localparam int MIN_COUNT_DEF  = 0;
    localparam int PRESCALE_DEF   = 1;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] RUN  = 2'd1;
    localparam logic [STATE_W-1:0] DONE = 2'd2;

endpackage

// File: rtl/sat_down_cntr_if.sv
// Command/status bundle of the saturating down-counter, plus the FSM state
// exposed for observation.
interface sat_down_cntr_if
    import sat_down_cntr_pkg::*;
#(
    parameter int N = CNTR_WIDTH_DEF
) ();

    // load/load_val and en are level commands sampled on every rising edge
    // (no handshake, never back-pressured); all status signals are registered
    // and describe the state reached on the most recent edge.
    logic               load;
    logic [N-1:0]       load_val;
    logic               en;
    logic [N-1:0]       cntr_out;
    logic               at_min;
    logic               busy;
    logic               done_pulse;
    logic [STATE_W-1:0] state;

    modport master (
        output load, load_val, en,
        input  cntr_out, at_min, busy, done_pulse, state
    );

    modport slave (
        input  load, load_val, en,
        output cntr_out, at_min, busy, done_pulse, state
    );

endinterface

// File: rtl/sat_down_cntr_tick_gen.sv
// Prescaler: counts enabled cycles 0..PRESCALE-1 and emits one tick on the
// cycle that wraps back to 0.
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // clr beats en so a load always restarts a full prescale period.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sat_down_cntr.sv
// Saturating down-counter: loads a start value, decrements once per prescaler
// tick while enabled, and stops at MIN_COUNT with a one-cycle done pulse.
module sat_down_cntr
    import sat_down_cntr_pkg::*;
#(
    parameter int N         = CNTR_WIDTH_DEF,
    parameter int MIN_COUNT = MIN_COUNT_DEF,
    parameter int PRESCALE  = PRESCALE_DEF
) (
    input  logic          clk,
    input  logic          reset,
    sat_down_cntr_if.slave bus
);

    localparam logic [N-1:0] MIN_V = N'(MIN_COUNT);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [N-1:0]       cntr;
    logic [N-1:0]       cntr_nxt;
    logic               at_min_q;
    logic               busy_q;
    logic               done_q;
    logic               tick;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .clr  (bus.load),
        .en   ((state == RUN) && bus.en),
        .tick (tick)
    );

    // A load overrides whatever the FSM would do, including a coincident tick.
    always_comb begin
        state_nxt = state;
        cntr_nxt  = cntr;
        if (bus.load) begin
            if (bus.load_val > MIN_V) begin
                cntr_nxt  = bus.load_val;
                state_nxt = RUN;
            end else begin
                cntr_nxt  = MIN_V;
                state_nxt = IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = IDLE;
                end
                RUN: begin
                    if (tick && (cntr > MIN_V)) begin
                        cntr_nxt = cntr - 1'b1;
                        if ((cntr - 1'b1) == MIN_V) begin
                            state_nxt = DONE;
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Flags are derived from next-state values so they line up with cntr_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cntr     <= MIN_V;
            at_min_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cntr     <= cntr_nxt;
            at_min_q <= (cntr_nxt == MIN_V);
            busy_q   <= (state_nxt == RUN);
            done_q   <= (state_nxt == DONE);
        end
    end

    assign bus.cntr_out   = cntr;
    assign bus.at_min     = at_min_q;
    assign bus.busy       = busy_q;
    assign bus.done_pulse = done_q;
    assign bus.state      = state;

endmodule

// File: tb/tb_sat_down_cntr.sv
// Bench for sat_down_cntr: two instances (floor 0/prescale 1 and floor 2/
// prescale 3) driven by directed vectors, checked by a queue-based scoreboard.
module tb_sat_down_cntr;
    import sat_down_cntr_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sat_down_cntr_if #(.N(4)) bus_a ();
    sat_down_cntr_if #(.N(4)) bus_b ();

    sat_down_cntr #(.N(4), .MIN_COUNT(0), .PRESCALE(1)) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_a)
    );

    sat_down_cntr #(.N(4), .MIN_COUNT(2), .PRESCALE(3)) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_b)
    );

    // Record layout: {sel, cntr_out[3:0], at_min, busy, done_pulse}; sel=1 is dut_b.
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    // Monitor: outputs are valid every cycle, so compare whatever was queued.
    always @(negedge clk) begin : monitor
        logic [W-1:0] e;
        logic [W-1:0] act;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[7]) begin
                act = {1'b1, bus_b.cntr_out, bus_b.at_min, bus_b.busy, bus_b.done_pulse};
            end else begin
                act = {1'b0, bus_a.cntr_out, bus_a.at_min, bus_a.busy, bus_a.done_pulse};
            end
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s cyc %0d: got cntr=%0d at_min=%b busy=%b done=%b, want cntr=%0d at_min=%b busy=%b done=%b",
                         e[7] ? "dut_b" : "dut_a", cyc_n,
                         act[6:3], act[2], act[1], act[0], e[6:3], e[2], e[1], e[0]);
            end
        end
    end

    // Driver: apply one cycle of inputs to instance s, push the outcome expected
    // after the coming edge.
    task automatic cyc(input bit s, input bit r, input bit ld, input logic [3:0] v,
                       input bit e, input logic [3:0] c, input bit am, input bit bz,
                       input bit dn);
        reset          = r;
        bus_a.load     = !s && ld;
        bus_a.load_val = v;
        bus_a.en       = !s && e;
        bus_b.load     = s && ld;
        bus_b.load_val = v;
        bus_b.en       = s && e;
        @(posedge clk);
        #1;
        cyc_n++;
        exp_q.push_back({s, c, am, bz, dn});
    endtask

    initial begin
        // Reset state of both instances.
        cyc(0, 1, 0, 4'd0, 0, 4'd0, 1, 0, 0);
        cyc(1, 1, 0, 4'd0, 0, 4'd2, 1, 0, 0);

        // dut_a: load 5, count to 0 with a single done pulse, then hold.
        cyc(0, 0, 1, 4'd5, 1, 4'd5, 0, 1, 0);
        for (int k = 4; k >= 0; k--) begin
            cyc(0, 0, 0, 4'd0, 1, 4'(k), k == 0, k != 0, k == 0);
        end
        cyc(0, 0, 0, 4'd0, 1, 4'd0, 1, 0, 0);
        cyc(0, 0, 0, 4'd0, 1, 4'd0, 1, 0, 0);

        // dut_a: load 8, enable pattern 1,0,0,1 freezes the count.
        cyc(0, 0, 1, 4'd8, 1, 4'd8, 0, 1, 0);
        cyc(0, 0, 0, 4'd0, 1, 4'd7, 0, 1, 0);
        cyc(0, 0, 0, 4'd0, 0, 4'd7, 0, 1, 0);
        cyc(0, 0, 0, 4'd0, 0, 4'd7, 0, 1, 0);
        cyc(0, 0, 0, 4'd0, 1, 4'd6, 0, 1, 0);
        cyc(0, 0, 0, 4'd0, 1, 4'd5, 0, 1, 0);
        cyc(0, 0, 0, 4'd0, 1, 4'd4, 0, 1, 0);
        cyc(0, 0, 0, 4'd0, 1, 4'd3, 0, 1, 0);

        // dut_a: load 9 on a tick cycle at 3; load wins and the countdown restarts.
        cyc(0, 0, 1, 4'd9, 1, 4'd9, 0, 1, 0);
        for (int k = 8; k >= 4; k--) begin
            cyc(0, 0, 0, 4'd0, 1, 4'(k), 0, 1, 0);
        end

        // dut_a: reset at 4 aborts silently and overrides a coincident load.
        cyc(0, 1, 0, 4'd0, 1, 4'd0, 1, 0, 0);
        cyc(0, 1, 1, 4'd15, 1, 4'd0, 1, 0, 0);
        cyc(0, 0, 0, 4'd0, 1, 4'd0, 1, 0, 0);

        // dut_a: full countdown from 15.
        cyc(0, 0, 1, 4'd15, 1, 4'd15, 0, 1, 0);
        for (int k = 14; k >= 0; k--) begin
            cyc(0, 0, 0, 4'd0, 1, 4'(k), k == 0, k != 0, k == 0);
        end
        cyc(0, 0, 0, 4'd0, 1, 4'd0, 1, 0, 0);

        // dut_a: load issued during the DONE cycle takes priority.
        cyc(0, 0, 1, 4'd2, 1, 4'd2, 0, 1, 0);
        cyc(0, 0, 0, 4'd0, 1, 4'd1, 0, 1, 0);
        cyc(0, 0, 0, 4'd0, 1, 4'd0, 1, 0, 1);
        cyc(0, 0, 1, 4'd3, 1, 4'd3, 0, 1, 0);
        cyc(0, 0, 0, 4'd0, 1, 4'd2, 0, 1, 0);
        cyc(0, 0, 0, 4'd0, 1, 4'd1, 0, 1, 0);
        cyc(0, 0, 0, 4'd0, 1, 4'd0, 1, 0, 1);
        cyc(0, 0, 0, 4'd0, 1, 4'd0, 1, 0, 0);

        // dut_a: load of the floor value goes straight to IDLE.
        cyc(0, 0, 1, 4'd0, 1, 4'd0, 1, 0, 0);
        cyc(0, 0, 0, 4'd0, 1, 4'd0, 1, 0, 0);

        // dut_b: load below the floor clamps to 2, stays idle.
        cyc(1, 0, 1, 4'd1, 1, 4'd2, 1, 0, 0);
        cyc(1, 0, 0, 4'd0, 1, 4'd2, 1, 0, 0);
        cyc(1, 0, 0, 4'd0, 1, 4'd2, 1, 0, 0);

        // dut_b: load 6, one decrement per 3 enabled cycles, done after 12.
        cyc(1, 0, 1, 4'd6, 1, 4'd6, 0, 1, 0);
        for (int c = 1; c <= 12; c++) begin
            cyc(1, 0, 0, 4'd0, 1, 4'(6 - c / 3), (6 - c / 3) == 2, c < 12, c == 12);
        end
        cyc(1, 0, 0, 4'd0, 1, 4'd2, 1, 0, 0);

        // dut_b: en=0 freezes the prescaler mid-period.
        cyc(1, 0, 1, 4'd4, 1, 4'd4, 0, 1, 0);
        cyc(1, 0, 0, 4'd0, 1, 4'd4, 0, 1, 0);
        cyc(1, 0, 0, 4'd0, 1, 4'd4, 0, 1, 0);
        cyc(1, 0, 0, 4'd0, 0, 4'd4, 0, 1, 0);
        cyc(1, 0, 0, 4'd0, 0, 4'd4, 0, 1, 0);
        cyc(1, 0, 0, 4'd0, 1, 4'd3, 0, 1, 0);
        cyc(1, 0, 0, 4'd0, 1, 4'd3, 0, 1, 0);
        cyc(1, 0, 0, 4'd0, 1, 4'd3, 0, 1, 0);
        cyc(1, 0, 0, 4'd0, 1, 4'd2, 1, 0, 1);
        cyc(1, 0, 0, 4'd0, 1, 4'd2, 1, 0, 0);

        // dut_b: a reload clears a partly-counted prescaler.
        cyc(1, 0, 1, 4'd5, 1, 4'd5, 0, 1, 0);
        cyc(1, 0, 0, 4'd0, 1, 4'd5, 0, 1, 0);
        cyc(1, 0, 1, 4'd5, 1, 4'd5, 0, 1, 0);
        cyc(1, 0, 0, 4'd0, 1, 4'd5, 0, 1, 0);
        cyc(1, 0, 0, 4'd0, 1, 4'd5, 0, 1, 0);
        cyc(1, 0, 0, 4'd0, 1, 4'd4, 0, 1, 0);

        // dut_b: reset mid-run aborts with no pulse.
        cyc(1, 1, 0, 4'd0, 1, 4'd2, 1, 0, 0);
        cyc(1, 0, 0, 4'd0, 1, 4'd2, 1, 0, 0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
